servo_pwm_gen: RTL and testbench
================================

SERVO_PWM_GEN -- requirements
Module: servo_pwm_gen

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- CLK_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 1_000_000, timebase tick rate (1 us).
- FRAME_US, 20000, PWM frame length in ticks.
- MIN_US, 1000, pulse width in ticks for pos=0.
- MAX_US, 2000, pulse width in ticks for pos=255.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, in, 1, system clock.
- rst, in, 1, reset; asynchronous, active-high.
- enable, in, 1, run PWM frames while high.
- pos, in, 8, position command.
- pos_valid, in, 1, pos is offered.
- pos_ready, out, 1, block accepts pos this cycle.
- pwm, out, 1, servo drive; registered output.
- frame_start, out, 1, one-clk pulse at the first clk of each frame.

Function
REQ-003 The prescaler SHALL assert an internal tick every DIV = CLK_HZ/TICK_HZ clks; the prescaler SHALL be held at 0 in IDLE.
REQ-004 Pulse width SHALL be computed as W = MIN_US + floor(pos*(MAX_US-MIN_US)/255), with unsigned arithmetic wide enough that no intermediate overflows.
REQ-005 A handshake SHALL complete on a clk edge where pos_valid and pos_ready are both high; the accepted W SHALL be stored in a pending register.
REQ-006 pos_ready SHALL be high iff the pending register is empty; the pending register SHALL never be overwritten.
REQ-007 At every frame start, a full pending register SHALL be copied to the active width and emptied; pos_ready SHALL rise on the following clk.
REQ-008 The FSM SHALL have three states: IDLE, HIGH, LOW.
REQ-009 IDLE -> HIGH SHALL occur on the first clk with enable=1; that clk is a frame start, with the frame tick counter=0 and frame_start=1.
REQ-010 In HIGH, pwm SHALL be 1; HIGH -> LOW SHALL occur when the tick counter reaches the active W.
- pwm SHALL be high for exactly W*DIV clks per frame.
REQ-011 In LOW, pwm SHALL be 0; when the tick counter reaches FRAME_US, the tick counter SHALL wrap to 0 and the FSM SHALL go to HIGH with a new frame start.
- Frame period SHALL be exactly FRAME_US*DIV clks.
REQ-012 enable falling in HIGH SHALL NOT truncate the pulse: the FSM completes HIGH, then goes LOW -> IDLE at the end of the frame.
- enable falling in LOW SHALL end the frame immediately -> IDLE.
REQ-013 In IDLE, pwm SHALL be 0 and frame_start SHALL be 0.
- Handshakes SHALL still be accepted in IDLE; a pending width is applied at the next frame start.
REQ-014 A handshake on the same clk as a frame start SHALL be stored as pending for the next frame, not applied to the current one.
REQ-015 W = FRAME_US is a parameter error; parameter checks SHALL require MIN_US <= MAX_US < FRAME_US and DIV >= 1.

Reset
REQ-016 rst=1 SHALL force, asynchronously: state=IDLE, pwm=0, frame_start=0, pos_ready=1, pending empty, prescaler=0, tick counter=0, active W = width for pos=128.
REQ-017 rst asserted mid-frame SHALL drop pwm to 0 immediately, and SHALL discard any pending command.

Verification
Bench parameters: CLK_HZ=4, TICK_HZ=1, FRAME_US=40, MIN_US=10, MAX_US=20 (DIV=4).
REQ-018 Reset, no command, enable=1 -> frame_start pulses every 160 clks; pwm high for 60 clks (W=15) per frame.
REQ-019 pos=0 accepted in IDLE, then enable=1 -> first frame pwm high 40 clks; pos=255 accepted mid-frame -> the current frame stays 40 clks and the next frame is 80 clks.
REQ-020 Offer two commands back-to-back -> the second is stalled (pos_ready=0) until the clk after the next frame start; no command is lost or overwritten.
REQ-021 enable dropped 8 clks into HIGH with W=15 -> pwm still high for 60 clks total, then IDLE at the frame end; enable dropped in LOW -> IDLE on the next clk, pwm=0.
REQ-022 rst pulsed in HIGH with a pending pos=255 -> pwm=0 asynchronously, pos_ready=1; re-enable -> pwm high 60 clks.

Source files
------------

// File: rtl/servo_pwm_gen.sv
// Servo PWM generator: a 1-tick prescaler drives a frame tick counter; an FSM shapes
// the pulse, and position commands are buffered in a one-deep pending slot.
module servo_pwm_gen #(
    parameter int unsigned CLK_HZ   = 100_000_000,
    parameter int unsigned TICK_HZ  = 1_000_000,
    parameter int unsigned FRAME_US = 20000,
    parameter int unsigned MIN_US   = 1000,
    parameter int unsigned MAX_US   = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] pos,
    input  logic       pos_valid,
    output logic       pos_ready,
    output logic       pwm,
    output logic       frame_start
);

    localparam int unsigned DIV  = CLK_HZ / TICK_HZ;
    localparam int unsigned SPAN = MAX_US - MIN_US;
    localparam int unsigned TW   = $clog2(FRAME_US + 1);
    localparam int unsigned DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PW   = 8 + $clog2(SPAN + 1) + 1;
    localparam logic [TW-1:0] RESET_W = TW'(MIN_US + (64'd128 * SPAN) / 64'd255);

    generate
        if (!(MIN_US <= MAX_US && MAX_US < FRAME_US && DIV >= 1)) begin : g_param_error
            $error("servo_pwm_gen: need MIN_US <= MAX_US < FRAME_US and CLK_HZ/TICK_HZ >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t          state, state_n;
    logic [DW-1:0]   presc, presc_n;
    logic [TW-1:0]   tcnt, tcnt_n;
    logic [TW-1:0]   active_w, active_n;
    logic [TW-1:0]   pend_w, pend_w_n;
    logic            pend_full, pend_full_n;
    logic            stop_req, stop_n;
    logic            pwm_n, fs_n;
    logic            frame_go;
    logic            tick;
    logic [TW-1:0]   tcnt_inc;
    logic [TW-1:0]   eff_w;
    logic [TW-1:0]   w_new;

    assign tick      = (presc == DW'(DIV - 1));
    assign tcnt_inc  = tcnt + TW'(1);
    assign eff_w     = pend_full ? pend_w : active_w;
    assign w_new     = TW'(MIN_US) + TW'((PW'(pos) * PW'(SPAN)) / PW'(255));
    assign pos_ready = !pend_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            presc       <= '0;
            tcnt        <= '0;
            active_w    <= RESET_W;
            pend_w      <= '0;
            pend_full   <= 1'b0;
            stop_req    <= 1'b0;
            pwm         <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            presc       <= presc_n;
            tcnt        <= tcnt_n;
            active_w    <= active_n;
            pend_w      <= pend_w_n;
            pend_full   <= pend_full_n;
            stop_req    <= stop_n;
            pwm         <= pwm_n;
            frame_start <= fs_n;
        end
    end

    always_comb begin
        state_n     = state;
        presc_n     = presc;
        tcnt_n      = tcnt;
        active_n    = active_w;
        pend_w_n    = pend_w;
        pend_full_n = pend_full;
        stop_n      = stop_req;
        pwm_n       = 1'b0;
        fs_n        = 1'b0;
        frame_go    = 1'b0;

        case (state)
            IDLE: begin
                presc_n  = '0;
                tcnt_n   = '0;
                stop_n   = 1'b0;
                frame_go = enable;
            end
            HIGH: begin
                pwm_n = 1'b1;
                // enable dropping mid-pulse is remembered so LOW runs to the frame end
                if (!enable) stop_n = 1'b1;
                if (tick) begin
                    presc_n = '0;
                    tcnt_n  = tcnt_inc;
                    if (tcnt_inc == active_w) begin
                        state_n = LOW;
                        pwm_n   = 1'b0;
                    end
                end else begin
                    presc_n = presc + DW'(1);
                end
            end
            LOW: begin
                if (!enable && !stop_req) begin
                    state_n = IDLE;
                    presc_n = '0;
                    tcnt_n  = '0;
                end else if (tick) begin
                    presc_n = '0;
                    if (tcnt_inc == TW'(FRAME_US)) begin
                        if (enable) begin
                            frame_go = 1'b1;
                        end else begin
                            state_n = IDLE;
                            tcnt_n  = '0;
                        end
                    end else begin
                        tcnt_n = tcnt_inc;
                    end
                end else begin
                    presc_n = presc + DW'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (frame_go) begin
            state_n = (eff_w == '0) ? LOW : HIGH;
            pwm_n   = (eff_w != '0);
            fs_n    = 1'b1;
            presc_n = '0;
            tcnt_n  = '0;
            stop_n  = 1'b0;
            if (pend_full) begin
                active_n    = pend_w;
                pend_full_n = 1'b0;
            end
        end

        // Uses the pre-edge pend_full, so a command landing on a frame start waits a frame
        if (pos_valid && !pend_full) begin
            pend_w_n    = w_new;
            pend_full_n = 1'b1;
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: stimulus queues expected per-frame pulse width and
// period; a negedge monitor measures each frame and compares when the next one starts.
module tb_servo_pwm_gen;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] pos;
    logic       pos_valid;
    logic       pos_ready;
    logic       pwm;
    logic       frame_start;

    typedef struct {
        int width;
        int period;
    } frame_t;

    frame_t exp_q[$];
    int     errors;
    int     checks;

    servo_pwm_gen #(
        .CLK_HZ  (4),
        .TICK_HZ (1),
        .FRAME_US(40),
        .MIN_US  (10),
        .MAX_US  (20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .pos        (pos),
        .pos_valid  (pos_valid),
        .pos_ready  (pos_ready),
        .pwm        (pwm),
        .frame_start(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_frame(input int width, input int period);
        frame_t f;
        f.width  = width;
        f.period = period;
        exp_q.push_back(f);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_fs(input string name);
        int found;
        found = 0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk);
            #2;
            if (frame_start) begin
                found = 1;
                break;
            end
        end
        check(name, found, 1);
    endtask

    // Monitor: period 0 in a record means the frame was followed by an idle gap
    initial begin : monitor
        bit     open;
        int     hi;
        int     cyc;
        int     avail;
        frame_t e;
        open = 0;
        hi   = 0;
        cyc  = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                open = 0;
                hi   = 0;
                cyc  = 0;
            end else begin
                if (frame_start) begin
                    if (open) begin
                        avail = exp_q.size();
                        check("frame_expected", (avail > 0) ? 1 : 0, 1);
                        if (avail > 0) begin
                            e = exp_q.pop_front();
                            check("frame_width", hi, e.width);
                            if (e.period != 0) check("frame_period", cyc, e.period);
                        end
                    end
                    open = 1;
                    hi   = 0;
                    cyc  = 0;
                end
                if (open) begin
                    cyc++;
                    if (pwm) hi++;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int stall;
        int fs_seen;
        int hi_seen;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        enable    = 1'b0;
        pos       = 8'd0;
        pos_valid = 1'b0;

        step(3);
        check("reset_pwm", int'(pwm), 0);
        check("reset_frame_start", int'(frame_start), 0);
        check("reset_pos_ready", int'(pos_ready), 1);
        rst = 1'b0;
        step(2);

        // Default width for pos=128 is 15 ticks = 60 clks; period 160 clks
        push_frame(60, 160);
        push_frame(60, 160);
        push_frame(60, 0);
        enable = 1'b1;
        wait_fs("start_f1");
        wait_fs("start_f2");
        wait_fs("start_f3");
        step(80);
        enable = 1'b0;
        step(1);
        check("low_drop_pwm", int'(pwm), 0);
        step(10);

        // pos=0 accepted in IDLE, applied at the next frame start
        pos       = 8'd0;
        pos_valid = 1'b1;
        step(1);
        pos_valid = 1'b0;
        check("idle_cmd_pending", int'(pos_ready), 0);
        push_frame(40, 160);
        push_frame(80, 160);
        enable = 1'b1;
        step(1);
        check("restart_from_idle", int'(frame_start), 1);
        check("pending_consumed", int'(pos_ready), 1);
        step(20);
        pos       = 8'd255;
        pos_valid = 1'b1;
        step(1);
        pos_valid = 1'b0;
        check("midframe_cmd_pending", int'(pos_ready), 0);

        // Back-to-back commands: second stalls until the clk after the next frame start
        push_frame(40, 160);
        push_frame(60, 0);
        wait_fs("start_f5");
        pos       = 8'd0;
        pos_valid = 1'b1;
        step(1);
        pos   = 8'd128;
        stall = 0;
        for (int i = 0; i < 400; i++) begin
            if (pos_ready) break;
            stall++;
            step(1);
        end
        check("second_cmd_stall", stall, 159);
        step(1);
        pos_valid = 1'b0;
        check("second_cmd_taken", int'(pos_ready), 0);

        // enable dropped 8 clks into the pulse: pulse completes, then idle at frame end
        wait_fs("start_f7");
        step(7);
        enable  = 1'b0;
        fs_seen = 0;
        hi_seen = 0;
        for (int i = 0; i < 300; i++) begin
            step(1);
            if (frame_start) fs_seen++;
            if (pwm) hi_seen++;
        end
        check("no_frame_after_stop", fs_seen, 0);
        check("pulse_after_drop", hi_seen, 52);

        // Handshake on the frame-start clk goes to the following frame
        push_frame(60, 160);
        push_frame(80, 160);
        pos       = 8'd255;
        pos_valid = 1'b1;
        enable    = 1'b1;
        step(1);
        pos_valid = 1'b0;
        check("fs_cmd_frame_start", int'(frame_start), 1);
        check("fs_cmd_pending", int'(pos_ready), 0);
        wait_fs("start_f9");
        wait_fs("start_f10");

        // Reset in HIGH with pos=255 pending: pending dropped, width back to 15 ticks
        pos       = 8'd255;
        pos_valid = 1'b1;
        step(1);
        pos_valid = 1'b0;
        check("rst_case_pending", int'(pos_ready), 0);
        step(8);
        check("rst_case_in_high", int'(pwm), 1);
        rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_ready", int'(pos_ready), 1);
        check("async_rst_fs", int'(frame_start), 0);
        step(2);
        push_frame(60, 160);
        rst = 1'b0;
        wait_fs("start_f11");
        wait_fs("start_f12");
        step(2);
        rst = 1'b1;
        step(2);
        check("frames_left", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
